cache_ctrl: RTL and testbench

Finite-state controller that sequences the direct-mapped write-back cache storage block between the CPU data port and a handshake-based main memory. It serves hits combinationally. On a miss it stalls the CPU, writes back a dirty victim line word by word, refills the line from memory, then retries the access. It sits between the CPU memory stage and the external memory bus, driving the storage block's store, edit and invalid controls.

---
 rtl/cache_pkg.sv | 46 ++++
 rtl/cache_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cache_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
//------------------------------------------------------------------------------
// Module      : cache_pkg
// Description : Shared definitions for the direct-mapped write-back cache
//               controller. Holds the controller state encoding, default
//               width constants and helpers that locate the tag, line-index
//               and word-offset fields inside a byte address.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;

    // Default widths. The tag width must agree with the storage block.
    localparam int c_word_bits        = 32;
    localparam int c_addr_bits        = 32;
    localparam int c_tag_bits         = 22;
    localparam int c_word_bytes_width = 2;
    localparam int c_line_words_width = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BACK = 2'd1,
        S_FILL = 2'd2
    } ctrl_state_e;

    // Address layout, MSB to LSB: {tag, index, word offset, byte offset}.

    // Lowest bit of the word-offset field.
    function automatic int word_lsb(input int word_bytes_width);
        return word_bytes_width;
    endfunction

    // Lowest bit of the line-index field.
    function automatic int index_lsb(input int line_words_width,
                                     input int word_bytes_width);
        return line_words_width + word_bytes_width;
    endfunction

    // Lowest bit of the tag field (the index field ends just below it).
    function automatic int tag_lsb(input int addr_bits, input int tag_bits);
        return addr_bits - tag_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cache_ctrl.sv
//------------------------------------------------------------------------------
// Module      : cache_ctrl
// Description : FSM sequencing a direct-mapped write-back cache storage block
//               between the CPU data port and a handshake main memory.
//               Hits are served combinationally; a miss stalls the CPU, writes
//               back a dirty victim word by word, refills the line and then
//               retries the access from S_IDLE.
// Ports       : clk, rst                     - clock, sync active-high reset
//               cpu_req/we/addr/din/dout     - CPU data port
//               cpu_stall                    - CPU must hold request while high
//               cache_addr/din               - storage address / write data
//               cache_store/edit/invalid     - storage controls
//               cache_hit/valid/dirty/tag/dout - storage status and data
//               mem_cs/we/addr/dout          - memory request
//               mem_din/ack                  - memory response
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_ctrl
    import cache_pkg::*;
#(
    parameter int WORD_BITS        = c_word_bits,
    parameter int ADDR_BITS        = c_addr_bits,
    parameter int TAG_BITS         = c_tag_bits,
    parameter int WORD_BYTES_WIDTH = c_word_bytes_width,
    parameter int LINE_WORDS_WIDTH = c_line_words_width
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic [WORD_BITS-1:0] cache_din,
    output logic                 cache_store,
    output logic                 cache_edit,
    output logic                 cache_invalid,
    input  logic                 cache_hit,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    input  logic [WORD_BITS-1:0] cache_dout,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack
);

    localparam int c_tag_lsb    = tag_lsb(ADDR_BITS, TAG_BITS);
    localparam int c_index_lsb  = index_lsb(LINE_WORDS_WIDTH, WORD_BYTES_WIDTH);
    localparam int c_index_bits = c_tag_lsb - c_index_lsb;

    localparam logic [LINE_WORDS_WIDTH-1:0] c_cnt_one  = 1;
    localparam logic [LINE_WORDS_WIDTH-1:0] c_cnt_zero = '0;

    ctrl_state_e                 r_state;
    ctrl_state_e                 w_state_next;
    logic [LINE_WORDS_WIDTH-1:0] r_cnt;
    logic [LINE_WORDS_WIDTH-1:0] w_cnt_next;

    logic [c_index_bits-1:0]     w_index;
    logic [TAG_BITS-1:0]         w_cpu_tag;
    logic [ADDR_BITS-1:0]        w_back_addr;
    logic [ADDR_BITS-1:0]        w_fill_addr;
    logic                        w_last_word;

    assign w_index     = cpu_addr[c_tag_lsb-1 -: c_index_bits];
    assign w_cpu_tag   = cpu_addr[ADDR_BITS-1 -: TAG_BITS];
    // Victim lines are written back under the stored tag, refills use the
    // CPU tag; both walk the line with the beat counter.
    assign w_back_addr = {cache_tag, w_index, r_cnt, {WORD_BYTES_WIDTH{1'b0}}};
    assign w_fill_addr = {w_cpu_tag, w_index, r_cnt, {WORD_BYTES_WIDTH{1'b0}}};
    assign w_last_word = &r_cnt;

    assign cpu_dout      = cache_dout;
    // Reserved for a future flush command.
    assign cache_invalid = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= c_cnt_zero;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        cpu_stall    = 1'b0;
        cache_addr   = cpu_addr;
        cache_din    = cpu_din;
        cache_store  = 1'b0;
        cache_edit   = 1'b0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = w_fill_addr;
        mem_dout     = cache_dout;

        case (r_state)
            S_IDLE: begin
                if (cpu_req) begin
                    if (cache_hit) begin
                        // Also completes a write miss on its retry cycle.
                        cache_edit = cpu_we;
                    end else begin
                        cpu_stall    = 1'b1;
                        w_cnt_next   = c_cnt_zero;
                        w_state_next = (cache_valid && cache_dirty) ? S_BACK : S_FILL;
                    end
                end
            end

            S_BACK: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = w_back_addr;
                cache_addr = w_back_addr;
                if (mem_ack) begin
                    // Counter wraps to zero on the last beat, ready for the fill.
                    w_cnt_next = r_cnt + c_cnt_one;
                    if (w_last_word) begin
                        w_state_next = S_FILL;
                    end
                end
            end

            S_FILL: begin
                cpu_stall  = 1'b1;
                mem_cs     = 1'b1;
                mem_addr   = w_fill_addr;
                cache_addr = w_fill_addr;
                if (mem_ack) begin
                    cache_store = 1'b1;
                    cache_din   = mem_din;
                    w_cnt_next  = r_cnt + c_cnt_one;
                    if (w_last_word) begin
                        w_state_next = S_IDLE;
                    end
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = c_cnt_zero;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_cache_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_cache_ctrl
// Description : Self-checking bench for cache_ctrl. Surrounds the controller
//               with a behavioural direct-mapped storage block and a
//               handshake memory with programmable ack delay. Expected memory
//               transactions are queued when a request is issued and checked
//               by the memory as each beat completes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_din, cpu_dout;
    logic        cpu_stall;
    logic [31:0] cache_addr, cache_din;
    logic        cache_store, cache_edit, cache_invalid;
    logic        cache_hit, cache_valid, cache_dirty;
    logic [21:0] cache_tag;
    logic [31:0] cache_dout;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_dout, mem_din;
    logic        mem_ack;

    int n_cmp = 0;
    int n_bad = 0;

    int ack_delay = 0;
    logic spurious = 1'b0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } mem_txn_t;
    mem_txn_t sb[$];

    always #5 clk = ~clk;

    cache_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_din       (cpu_din),
        .cpu_dout      (cpu_dout),
        .cpu_stall     (cpu_stall),
        .cache_addr    (cache_addr),
        .cache_din     (cache_din),
        .cache_store   (cache_store),
        .cache_edit    (cache_edit),
        .cache_invalid (cache_invalid),
        .cache_hit     (cache_hit),
        .cache_valid   (cache_valid),
        .cache_dirty   (cache_dirty),
        .cache_tag     (cache_tag),
        .cache_dout    (cache_dout),
        .mem_cs        (mem_cs),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_dout      (mem_dout),
        .mem_din       (mem_din),
        .mem_ack       (mem_ack)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] addr, input logic [31:0] data);
        mem_txn_t t;
        t.we = we; t.addr = addr; t.data = data;
        sb.push_back(t);
    endtask

    // Cycle timeline: negedge+1 drive, +2 storage, +3 memory, +4 check.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    //--------------------------------------------------------------------------
    // Storage block model: 64 lines x 4 words, reads evaluated once per cycle
    //--------------------------------------------------------------------------
    logic        st_valid [64];
    logic        st_dirty [64];
    logic [21:0] st_tag   [64];
    logic [31:0] st_data  [256];

    initial begin
        for (int i = 0; i < 64; i++) begin
            st_valid[i] = 1'b0;
            st_dirty[i] = 1'b0;
            st_tag[i]   = '0;
        end
        for (int i = 0; i < 256; i++) st_data[i] = '0;
    end

    always @(negedge clk) begin
        #2;
        cache_valid = st_valid[cache_addr[9:4]];
        cache_dirty = st_dirty[cache_addr[9:4]];
        cache_tag   = st_tag[cache_addr[9:4]];
        cache_hit   = cache_valid && (cache_tag == cache_addr[31:10]);
        cache_dout  = st_data[{cache_addr[9:4], cache_addr[3:2]}];
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) begin
                st_valid[i] <= 1'b0;
                st_dirty[i] <= 1'b0;
            end
        end else if (cache_store) begin
            st_data[{cache_addr[9:4], cache_addr[3:2]}] <= cache_din;
            st_tag[cache_addr[9:4]]   <= cache_addr[31:10];
            st_valid[cache_addr[9:4]] <= 1'b1;
            st_dirty[cache_addr[9:4]] <= 1'b0;
        end else if (cache_edit) begin
            st_data[{cache_addr[9:4], cache_addr[3:2]}] <= cache_din;
            st_dirty[cache_addr[9:4]] <= 1'b1;
        end
    end

    //--------------------------------------------------------------------------
    // Memory model: acks after ack_delay wait cycles, checks request stability
    // across waits and pops the scoreboard on each completed beat.
    //--------------------------------------------------------------------------
    int          wait_n = 0;
    logic        lat_we;
    logic [31:0] lat_addr, lat_dout;

    always @(negedge clk) begin
        #3;
        mem_ack = 1'b0;
        mem_din = '0;
        if (mem_cs) begin
            if (wait_n == 0) begin
                lat_we = mem_we; lat_addr = mem_addr; lat_dout = mem_dout;
            end else begin
                check("hold_mem_addr", mem_addr, lat_addr);
                check("hold_mem_we", {31'd0, mem_we}, {31'd0, lat_we});
                if (lat_we) check("hold_mem_dout", mem_dout, lat_dout);
            end
            if (wait_n >= ack_delay) begin
                mem_ack = 1'b1;
                mem_din = mem_we ? 32'd0 : memfn(mem_addr);
                wait_n  = 0;
                if (sb.size() == 0) begin
                    check("mem_unexpected_beat", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    mem_txn_t t;
                    t = sb.pop_front();
                    check("mem_beat_addr", mem_addr, t.addr);
                    check("mem_beat_we", {31'd0, mem_we}, {31'd0, t.we});
                    if (t.we) check("mem_beat_wdata", mem_dout, t.data);
                end
            end else begin
                wait_n++;
            end
        end else begin
            wait_n = 0;
            if (spurious) begin
                mem_ack = 1'b1;
                mem_din = 32'hBAD0_BAD0;
            end
        end
    end

    // Counts stalled cycles (including the detect cycle) and stores until the
    // access completes; leaves time at the settled point of the hit cycle.
    task automatic run_miss(output int stall_n, output int store_n);
        stall_n = 0;
        store_n = 0;
        for (int k = 0; k < 200; k++) begin
            if (cache_store) store_n++;
            if (!cpu_stall) break;
            stall_n++;
            step();
            settle();
        end
    endtask

    initial begin
        int stall_n, store_n;

        rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
        cpu_addr = '0; cpu_din = '0;
        mem_ack = 1'b0; mem_din = '0;

        step(); settle();
        step(); settle();
        check("rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("rst_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_mem_we", {31'd0, mem_we}, 32'd0);
        check("rst_strobes", {29'd0, cache_store, cache_edit, cache_invalid}, 32'd0);
        step(); rst = 1'b0; settle();
        check("idle_mem_cs", {31'd0, mem_cs}, 32'd0);

        // Clean read miss
        step();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1004;
        for (int i = 0; i < 4; i++) push(1'b0, 32'h0000_1000 + 32'(i * 4), '0);
        settle();
        run_miss(stall_n, store_n);
        check("clean_stall_cycles", 32'(stall_n), 32'd5);
        check("clean_store_count", 32'(store_n), 32'd4);
        check("clean_dout", cpu_dout, memfn(32'h0000_1004));
        check("clean_hit_mem_cs", {31'd0, mem_cs}, 32'd0);

        // Write hit
        step();
        cpu_we = 1'b1; cpu_addr = 32'h0000_1008; cpu_din = 32'hDEAD_BEEF;
        settle();
        check("wr_hit_stall", {31'd0, cpu_stall}, 32'd0);
        check("wr_hit_edit", {31'd0, cache_edit}, 32'd1);
        check("wr_hit_din", cache_din, 32'hDEAD_BEEF);
        check("wr_hit_mem_cs", {31'd0, mem_cs}, 32'd0);
        step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        settle();
        check("wr_edit_pulse", {31'd0, cache_edit}, 32'd0);

        // Dirty read miss on the same index
        step();
        cpu_req = 1'b1; cpu_addr = 32'h0040_1000;
        push(1'b1, 32'h0000_1000, memfn(32'h0000_1000));
        push(1'b1, 32'h0000_1004, memfn(32'h0000_1004));
        push(1'b1, 32'h0000_1008, 32'hDEAD_BEEF);
        push(1'b1, 32'h0000_100C, memfn(32'h0000_100C));
        for (int i = 0; i < 4; i++) push(1'b0, 32'h0040_1000 + 32'(i * 4), '0);
        settle();
        run_miss(stall_n, store_n);
        check("dirty_stall_cycles", 32'(stall_n), 32'd9);
        check("dirty_store_count", 32'(store_n), 32'd4);
        check("dirty_dout", cpu_dout, memfn(32'h0040_1000));
        check("dirty_sb_drained", 32'(sb.size()), 32'd0);

        // Slow memory: three wait cycles per beat
        ack_delay = 3;
        step();
        cpu_addr = 32'h0000_2010;
        for (int i = 0; i < 4; i++) push(1'b0, 32'h0000_2010 + 32'(i * 4), '0);
        settle();
        run_miss(stall_n, store_n);
        check("slow_stall_cycles", 32'(stall_n), 32'd17);
        check("slow_store_count", 32'(store_n), 32'd4);
        check("slow_dout", cpu_dout, memfn(32'h0000_2010));
        ack_delay = 0;

        // Reset during the second fill beat
        step();
        cpu_addr = 32'h0000_3024;
        push(1'b0, 32'h0000_3020, '0);
        push(1'b0, 32'h0000_3024, '0);
        settle();
        check("abort_detect_stall", {31'd0, cpu_stall}, 32'd1);
        step(); settle();
        check("abort_beat0_addr", mem_addr, 32'h0000_3020);
        step();
        rst = 1'b1; cpu_req = 1'b0;
        settle();
        check("abort_beat1_addr", mem_addr, 32'h0000_3024);
        step();
        rst = 1'b0;
        settle();
        check("abort_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("abort_stall", {31'd0, cpu_stall}, 32'd0);
        check("abort_store", {31'd0, cache_store}, 32'd0);
        step();
        cpu_req = 1'b1; cpu_addr = 32'h0000_3024;
        for (int i = 0; i < 4; i++) push(1'b0, 32'h0000_3020 + 32'(i * 4), '0);
        settle();
        run_miss(stall_n, store_n);
        check("refill_stall_cycles", 32'(stall_n), 32'd5);
        check("refill_store_count", 32'(store_n), 32'd4);
        check("refill_dout", cpu_dout, memfn(32'h0000_3024));

        // Spurious ack while idle
        step();
        cpu_req = 1'b0; spurious = 1'b1;
        settle();
        check("spur_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("spur_strobes", {29'd0, cache_store, cache_edit, cache_invalid}, 32'd0);
        check("spur_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        spurious = 1'b0;
        settle();
        check("spur_after_mem_cs", {31'd0, mem_cs}, 32'd0);
        check("spur_after_stall", {31'd0, cpu_stall}, 32'd0);
        step();
        cpu_req = 1'b1; cpu_addr = 32'h0000_3028;
        settle();
        check("spur_hit_stall", {31'd0, cpu_stall}, 32'd0);
        check("spur_hit_dout", cpu_dout, memfn(32'h0000_3028));
        check("spur_hit_mem_cs", {31'd0, mem_cs}, 32'd0);
        step();
        cpu_req = 1'b0;
        settle();
        check("final_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
